neuron_layer_sequencer: RTL and testbench

Layer-level scheduler for the single shared neuron datapath. One `start` pulse runs K neurons back-to-back through the same neuron. For each neuron the block drives the input and weight memory read addresses over N serial cycles, waits for the neuron's `ready`, and emits the result tagged with its neuron index. It sits between the top-level control and the neuron/weight-memory pair.

---
 rtl/neuron_pkg.sv | 31 +++
 rtl/mod_counter.sv | 31 +++
 rtl/neuron_layer_sequencer.sv | 126 ++++++++++++
 tb/tb_neuron_layer_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron layer sequencer: FSM state encoding,
// default layer geometry and a clog2 helper that never returns less than 1
// (so single-entry address/index ports keep a legal width).
// -----------------------------------------------------------------------------
package neuron_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_START   = 3'd1;
    localparam state_t ST_FEED    = 3'd2;
    localparam state_t ST_WAIT    = 3'd3;
    localparam state_t ST_CAPTURE = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    localparam int DEF_M = 18;
    localparam int DEF_N = 4;
    localparam int DEF_K = 3;

    // Bits needed to index v entries, minimum 1.
    function automatic int clog2_min1(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-MOD up counter with synchronous clear and count enable.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (priority over en)
//   en       : advance by one, wrapping MOD-1 -> 0
//   cnt      : current count
//   tc       : terminal count, high while cnt == MOD-1
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(MOD - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_layer_sequencer
// Runs K neurons back-to-back through one shared serial neuron. Per neuron:
// start pulse, N cycles of input/weight addresses, wait for ready, capture the
// result tagged with its neuron index.
//   clk, rst       : clock, synchronous active-high reset
//   start          : run a layer (sampled only in IDLE)
//   busy / done    : layer in progress / one-cycle completion pulse
//   in_addr        : input index j (FEED only, else 0)
//   w_addr         : weight index k*N + j (FEED only, else 0)
//   neuron_start   : one-cycle start to the neuron
//   neuron_ready   : neuron result valid (only looked at in WAIT)
//   neuron_out     : neuron result
//   res_valid      : one-cycle result strobe
//   res_idx/data   : registered neuron index and result
// Build option: define NEURON_RELU_EN to clamp negative results to 0 on capture.
// -----------------------------------------------------------------------------
module neuron_layer_sequencer
    import neuron_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int N = DEF_N,
    parameter int K = DEF_K,
    localparam int IW = clog2_min1(N),
    localparam int WW = clog2_min1(N * K),
    localparam int KW = clog2_min1(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] in_addr,
    output logic [WW-1:0] w_addr,
    output logic          neuron_start,
    input  logic          neuron_ready,
    input  logic [M-1:0]  neuron_out,
    output logic          res_valid,
    output logic [KW-1:0] res_idx,
    output logic [M-1:0]  res_data
);

    // N folded into the address width; N*K-1 always fits in WW bits, so the
    // product k*N + j cannot overflow.
    localparam logic [WW-1:0] N_W = WW'(N);

    state_t        state, state_nxt;
    logic [IW-1:0] j;
    logic [KW-1:0] k;
    logic          j_tc, k_tc;
    logic [M-1:0]  cap_val;

    // j runs only in FEED and is zero everywhere else.
    mod_counter #(.MOD(N), .W(IW)) u_j_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != ST_FEED),
        .en  (state == ST_FEED),
        .cnt (j),
        .tc  (j_tc)
    );

    // k advances on each non-final CAPTURE and is cleared while idle.
    mod_counter #(.MOD(K), .W(KW)) u_k_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_IDLE),
        .en  ((state == ST_CAPTURE) && !k_tc),
        .cnt (k),
        .tc  (k_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_START;
            ST_START:   state_nxt = ST_FEED;
            ST_FEED:    if (j_tc) state_nxt = ST_WAIT;
            ST_WAIT:    if (neuron_ready) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = k_tc ? ST_DONE : ST_START;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy         = (state != ST_IDLE);
        neuron_start = (state == ST_START);
        res_valid    = (state == ST_CAPTURE);
        done         = (state == ST_DONE);
        in_addr      = '0;
        w_addr       = '0;
        if (state == ST_FEED) begin
            in_addr = j;
            w_addr  = WW'(k) * N_W + WW'(j);
        end
    end

`ifdef NEURON_RELU_EN
    assign cap_val = neuron_out[M-1] ? '0 : neuron_out;
`else
    assign cap_val = neuron_out;
`endif

    // Result latch: loads on the WAIT->CAPTURE transition, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data <= '0;
            res_idx  <= '0;
        end else if ((state == ST_WAIT) && neuron_ready) begin
            res_data <= cap_val;
            res_idx  <= k;
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_layer_sequencer
// Directed bench for neuron_layer_sequencer (M=18, N=4, K=3). A small neuron
// model raises ready on the first WAIT cycle plus a per-neuron extra delay.
// Cycle c counts rising edges after the edge that sampled start (START = 1).
// -----------------------------------------------------------------------------
module tb_neuron_layer_sequencer;

    localparam int M = 18;
    localparam int N = 4;
    localparam int K = 3;

    logic         clk = 1'b0;
    logic         rst, start;
    logic         busy, done, neuron_start, neuron_ready, res_valid;
    logic [1:0]   in_addr;
    logic [3:0]   w_addr;
    logic [1:0]   res_idx;
    logic [M-1:0] res_data;
    logic [M-1:0] neuron_out = '0;

    always #5 clk = ~clk;

    neuron_layer_sequencer #(.M(M), .N(N), .K(K)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .in_addr      (in_addr),
        .w_addr       (w_addr),
        .neuron_start (neuron_start),
        .neuron_ready (neuron_ready),
        .neuron_out   (neuron_out),
        .res_valid    (res_valid),
        .res_idx      (res_idx),
        .res_data     (res_data)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- neuron model ----------------
    int           timer = 0;
    int           ncnt = 0;
    logic         rdy_m = 1'b0;
    logic         stray;
    int           extra[3];
    logic [M-1:0] vals[3];

    assign neuron_ready = rdy_m | stray;

    always @(negedge clk) begin
        if (rst) begin
            timer = 0;
            rdy_m = 1'b0;
        end else if (neuron_start) begin
            timer      = N + 1 + extra[ncnt % 3];
            rdy_m      = 1'b0;
            neuron_out = vals[ncnt % 3];
            ncnt++;
        end else if (timer == 1) begin
            rdy_m = 1'b1;
            timer = 0;
        end else if (timer > 1) begin
            timer--;
        end
        if (!busy) ncnt = 0;
    end

    // ---------------- observation ----------------
    int           vcyc[8];
    int           vidx[8];
    logic [M-1:0] vdat[8];
    int           nv, nd, nns;
    int           dcyc[4];
    int           nscyc[8];
    logic [3:0]   wa[64];
    logic [1:0]   ia[64];
    logic         bz[64];
    logic         rv[64];
    logic [M-1:0] rd[64];

    // Pulse start (cycle 0), then observe ncyc cycles. s1..s3: cycles with
    // start high; st: stray ready cycle; rc: reset cycle (0 = none).
    task automatic run_obs(input int ncyc, input int s1, input int s2, input int s3,
                           input int st, input int rc);
        nv = 0; nd = 0; nns = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= ncyc; c++) begin
            start = (c == s1) || (c == s2) || (c == s3);
            stray = (c == st);
            rst   = (c == rc);
            wa[c] = w_addr; ia[c] = in_addr; bz[c] = busy; rv[c] = res_valid; rd[c] = res_data;
            if (res_valid && nv < 8) begin
                vcyc[nv] = c; vidx[nv] = res_idx; vdat[nv] = res_data; nv++;
            end
            if (done && nd < 4) begin dcyc[nd] = c; nd++; end
            if (neuron_start && nns < 8) begin nscyc[nns] = c; nns++; end
            @(posedge clk);
            #1;
        end
        start = 1'b0; stray = 1'b0; rst = 1'b0;
    endtask

    initial begin
        int bad;
        int p, kk;
        logic [M-1:0] exp0;

        rst = 1'b1; start = 1'b0; stray = 1'b0;
        extra = '{0, 0, 0};
        vals  = '{18'd100, 18'd200, 18'd300};

        // ---- reset / idle ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nstart", neuron_start, 0);
        chk("rst_rvalid", res_valid, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_res_data", res_data, 0);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (busy || done || res_valid || neuron_start) bad++;
        end
        chk("idle_quiet", bad, 0);

        // ---- nominal run ----
        run_obs(25, 0, 0, 0, 0, 0);
        chk("nom_nres", nv, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("nom_vcyc%0d", i), vcyc[i], 7 * (i + 1));
            chk($sformatf("nom_vidx%0d", i), vidx[i], i);
            chk($sformatf("nom_vdat%0d", i), vdat[i], 100 * (i + 1));
            chk($sformatf("nom_nscyc%0d", i), nscyc[i], 1 + 7 * i);
        end
        chk("nom_nstart_cnt", nns, 3);
        chk("nom_ndone", nd, 1);
        chk("nom_done_cyc", dcyc[0], 22);
        for (int c = 1; c <= 22; c++) begin
            p  = (c - 1) % 7;
            kk = (c - 1) / 7;
            chk($sformatf("nom_w_addr_c%0d", c), wa[c], (p >= 1 && p <= 4) ? kk * 4 + p - 1 : 0);
            chk($sformatf("nom_in_addr_c%0d", c), ia[c], (p >= 1 && p <= 4) ? p - 1 : 0);
            chk($sformatf("nom_busy_c%0d", c), bz[c], 1);
        end
        chk("nom_busy_after", bz[23], 0);

        // ---- stalled neuron 1 + stray ready during FEED ----
        extra = '{0, 5, 0};
        run_obs(32, 0, 0, 0, 3, 0);
        chk("stall_nres", nv, 3);
        chk("stall_vcyc0", vcyc[0], 7);
        chk("stall_vcyc1", vcyc[1], 19);
        chk("stall_vidx1", vidx[1], 1);
        chk("stall_vdat1", vdat[1], 200);
        chk("stall_vcyc2", vcyc[2], 26);
        chk("stall_done_cyc", dcyc[0], 27);

        // ---- ReLU option ----
        extra = '{0, 0, 0};
        vals  = '{18'h3FFCE, 18'd77, 18'd5};
`ifdef NEURON_RELU_EN
        exp0 = '0;
`else
        exp0 = 18'h3FFCE;
`endif
        run_obs(25, 0, 0, 0, 0, 0);
        chk("relu_vdat0", vdat[0], exp0);
        chk("relu_hold", rd[10], exp0);
        chk("relu_vdat1", vdat[1], 77);
        chk("relu_vdat2", vdat[2], 5);

        // ---- start while busy, then start right after done ----
        vals = '{18'd100, 18'd200, 18'd300};
        run_obs(50, 3, 6, 23, 0, 0);
        chk("coll_nres", nv, 6);
        chk("coll_ndone", nd, 2);
        chk("coll_done0", dcyc[0], 22);
        chk("coll_done1", dcyc[1], 45);
        chk("coll_vcyc3", vcyc[3], 30);
        chk("coll_vidx3", vidx[3], 0);
        chk("coll_vidx5", vidx[5], 2);

        // ---- abort in WAIT of neuron 1 ----
        run_obs(25, 0, 0, 0, 0, 13);
        chk("abort_nres", nv, 1);
        chk("abort_ndone", nd, 0);
        chk("abort_busy", bz[14], 0);
        chk("abort_rvalid", rv[14], 0);
        chk("abort_res_data", rd[14], 0);
        chk("abort_w_addr", wa[14], 0);

        // ---- restart after abort ----
        run_obs(25, 0, 0, 0, 0, 0);
        chk("restart_w_addr0", wa[2], 0);
        chk("restart_w_addr1", wa[3], 1);
        chk("restart_vcyc0", vcyc[0], 7);
        chk("restart_vidx0", vidx[0], 0);
        chk("restart_nres", nv, 3);
        chk("restart_done", dcyc[0], 22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
